// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue-side controller for the multiplier functional unit.
// Accepts one ready multiply op at a time and launches it on the FU. The
// result and its destination tags are held in a one-entry buffer until the
// CDB grants it. A branch flush squashes the in-flight op, and the late FU
// result is dropped.
module mult_issue_ctrl #(
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned ROB_IDX_BITS  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // reservation station side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_rs1_v,
  input  logic [31:0]              req_rs2_v,
  input  logic [2:0]               req_funct3,
  input  logic [PHYS_REG_BITS-1:0] req_pd,
  input  logic [ROB_IDX_BITS-1:0]  req_rob_idx,
  // functional unit side
  output logic                     fu_start,
  output logic [31:0]              fu_rs1_v,
  output logic [31:0]              fu_rs2_v,
  output logic [2:0]               fu_funct3,
  input  logic                     fu_valid,
  input  logic [31:0]              fu_rd_v,
  // common data bus side
  output logic                     cdb_req,
  input  logic                     cdb_grant,
  output logic [31:0]              cdb_rd_v,
  output logic [PHYS_REG_BITS-1:0] cdb_pd,
  output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
  // control
  input  logic                     flush,
  output logic                     busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3W  = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                   r_state;
  logic [XLEN-1:0]          r_rs1_v;
  logic [XLEN-1:0]          r_rs2_v;
  logic [F3W-1:0]           r_funct3;
  logic [PHYS_REG_BITS-1:0] r_pd;
  logic [ROB_IDX_BITS-1:0]  r_rob_idx;
  logic [XLEN-1:0]          r_rd_v;
  logic [PHYS_REG_BITS-1:0] r_cdb_pd;
  logic [ROB_IDX_BITS-1:0]  r_cdb_rob_idx;

  logic w_req_ready;
  logic w_accept;
  logic w_cdb_req;

  // A new op may enter when idle, or in DONE on the very cycle the buffer
  // drains, which lets back-to-back ops overlap the broadcast. Held low while
  // reset is asserted.
  assign w_req_ready = rst_n && !flush &&
                       ((r_state == S_IDLE) || ((r_state == S_DONE) && cdb_grant));
  assign w_accept    = req_valid && w_req_ready;
  // flush suppresses the request immediately so a coincident grant is void.
  assign w_cdb_req   = (r_state == S_DONE) && !flush;

  // Control state, latched op and result buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rs1_v       <= '0;
      r_rs2_v       <= '0;
      r_funct3      <= '0;
      r_pd          <= '0;
      r_rob_idx     <= '0;
      r_rd_v        <= '0;
      r_cdb_pd      <= '0;
      r_cdb_rob_idx <= '0;
    end else begin
      // Accept happens only in IDLE or DONE, so operands are never disturbed
      // between START and the op's fu_valid.
      if (w_accept) begin
        r_rs1_v   <= req_rs1_v;
        r_rs2_v   <= req_rs2_v;
        r_funct3  <= req_funct3;
        r_pd      <= req_pd;
        r_rob_idx <= req_rob_idx;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_START;
        end
        S_START: begin
          r_state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            // A result arriving with the flush is already the one to drop.
            r_state <= fu_valid ? S_IDLE : S_DRAIN;
          end else if (fu_valid) begin
            r_rd_v        <= fu_rd_v;
            r_cdb_pd      <= r_pd;
            r_cdb_rob_idx <= r_rob_idx;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (cdb_grant) begin
            r_state <= w_accept ? S_START : S_IDLE;
          end
        end
        S_DRAIN: begin
          if (fu_valid) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign cdb_req     = w_cdb_req;
  assign fu_start    = (r_state == S_START);
  assign fu_rs1_v    = r_rs1_v;
  assign fu_rs2_v    = r_rs2_v;
  assign fu_funct3   = r_funct3;
  assign cdb_rd_v    = r_rd_v;
  assign cdb_pd      = r_cdb_pd;
  assign cdb_rob_idx = r_cdb_rob_idx;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl: single op, CDB backpressure with a
// back-to-back follow-on op, flush in WAIT, flush against a grant, and reset
// in the middle of an op.
module tb_mult_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_rs1_v = '0;
  logic [31:0] req_rs2_v = '0;
  logic [2:0]  req_funct3 = '0;
  logic [5:0]  req_pd = '0;
  logic [4:0]  req_rob_idx = '0;
  logic        fu_start;
  logic [31:0] fu_rs1_v;
  logic [31:0] fu_rs2_v;
  logic [2:0]  fu_funct3;
  logic        fu_valid = 1'b0;
  logic [31:0] fu_rd_v = '0;
  logic        cdb_req;
  logic        cdb_grant = 1'b0;
  logic [31:0] cdb_rd_v;
  logic [5:0]  cdb_pd;
  logic [4:0]  cdb_rob_idx;
  logic        flush = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mult_issue_ctrl #(.PHYS_REG_BITS(6), .ROB_IDX_BITS(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1_v  (req_rs1_v),
    .req_rs2_v  (req_rs2_v),
    .req_funct3 (req_funct3),
    .req_pd     (req_pd),
    .req_rob_idx(req_rob_idx),
    .fu_start   (fu_start),
    .fu_rs1_v   (fu_rs1_v),
    .fu_rs2_v   (fu_rs2_v),
    .fu_funct3  (fu_funct3),
    .fu_valid   (fu_valid),
    .fu_rd_v    (fu_rd_v),
    .cdb_req    (cdb_req),
    .cdb_grant  (cdb_grant),
    .cdb_rd_v   (cdb_rd_v),
    .cdb_pd     (cdb_pd),
    .cdb_rob_idx(cdb_rob_idx),
    .flush      (flush),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [2:0] f3, input logic [5:0] pd,
                           input logic [4:0] rob);
    req_valid   = 1'b1;
    req_rs1_v   = rs1;
    req_rs2_v   = rs2;
    req_funct3  = f3;
    req_pd      = pd;
    req_rob_idx = rob;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    #1;
    chk("rst_busy",      32'(busy),      0);
    chk("rst_fu_start",  32'(fu_start),  0);
    chk("rst_cdb_req",   32'(cdb_req),   0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rs1",       fu_rs1_v,       0);
    chk("rst_cdb_rd",    cdb_rd_v,       0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", 32'(req_ready), 1);

    // ---------------- single op, L=4 ----------------
    drive_req(7, 6, 3'b000, 6'd12, 5'd3);
    #1;
    chk("op1_req_ready", 32'(req_ready), 1);
    tick();                               // START
    req_valid = 1'b0;
    #1;
    chk("op1_fu_start", 32'(fu_start),  1);
    chk("op1_rs1",      fu_rs1_v,       7);
    chk("op1_rs2",      fu_rs2_v,       6);
    chk("op1_f3",       32'(fu_funct3), 0);
    chk("op1_busy",     32'(busy),      1);
    tick();                               // WAIT 1
    #1;
    chk("op1_start_pulse", 32'(fu_start), 0);
    chk("op1_rs1_stable",  fu_rs1_v,      7);
    tick();                               // WAIT 2
    tick();                               // WAIT 3
    #1;
    chk("op1_no_req_early", 32'(cdb_req), 0);
    tick();                               // WAIT 4: FU result arrives
    fu_valid = 1'b1;
    fu_rd_v  = 42;
    #1;
    chk("op1_no_req_cap", 32'(cdb_req), 0);
    tick();                               // DONE, 6th cycle after accept
    fu_valid = 1'b0;
    fu_rd_v  = '0;
    #1;
    chk("op1_cdb_req",   32'(cdb_req),     1);
    chk("op1_cdb_rd",    cdb_rd_v,         42);
    chk("op1_cdb_pd",    32'(cdb_pd),      12);
    chk("op1_cdb_rob",   32'(cdb_rob_idx), 3);
    chk("op1_ready_ng",  32'(req_ready),   0);
    cdb_grant = 1'b1;
    #1;
    chk("op1_ready_g",   32'(req_ready),   1);
    tick();
    cdb_grant = 1'b0;
    #1;
    chk("op1_req_drop",  32'(cdb_req),     0);
    chk("op1_idle",      32'(busy),        0);

    // ------- backpressure (mulh 0x80000000^2, L=2) + back-to-back -------
    drive_req(32'h8000_0000, 32'h8000_0000, 3'b001, 6'd5, 5'd9);
    tick();                               // START
    req_valid = 1'b0;
    #1;
    chk("bp_fu_start", 32'(fu_start),  1);
    chk("bp_f3",       32'(fu_funct3), 1);
    tick();                               // WAIT 1
    tick();                               // WAIT 2: result
    fu_valid = 1'b1;
    fu_rd_v  = 32'h4000_0000;
    tick();                               // DONE
    fu_valid = 1'b0;
    fu_rd_v  = '0;
    drive_req(3, 5, 3'b000, 6'd20, 5'd21);  // second op waiting
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_cdb_req",   32'(cdb_req),   1);
      chk("bp_cdb_rd",    cdb_rd_v,       32'h4000_0000);
      chk("bp_cdb_pd",    32'(cdb_pd),    5);
      chk("bp_ready",     32'(req_ready), 0);
      chk("bp_no_start",  32'(fu_start),  0);
      tick();
    end
    cdb_grant = 1'b1;
    #1;
    chk("b2b_cdb_req",  32'(cdb_req),     1);
    chk("b2b_cdb_rob",  32'(cdb_rob_idx), 9);
    chk("b2b_ready",    32'(req_ready),   1);
    tick();                               // op2 START right after grant
    cdb_grant = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("b2b_fu_start", 32'(fu_start), 1);
    chk("b2b_rs1",      fu_rs1_v,      3);
    chk("b2b_rs2",      fu_rs2_v,      5);
    chk("b2b_req_off",  32'(cdb_req),  0);
    tick();                               // WAIT 1: L=1 result
    fu_valid = 1'b1;
    fu_rd_v  = 15;
    tick();                               // DONE
    fu_valid = 1'b0;
    fu_rd_v  = '0;
    #1;
    chk("b2b_cdb_req2", 32'(cdb_req),     1);
    chk("b2b_cdb_rd2",  cdb_rd_v,         15);
    chk("b2b_cdb_pd2",  32'(cdb_pd),      20);
    chk("b2b_cdb_rob2", 32'(cdb_rob_idx), 21);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    #1;
    chk("b2b_idle", 32'(busy), 0);

    // ---------------- flush in WAIT ----------------
    drive_req(1, 2, 3'b000, 6'd1, 5'd1);
    tick();                               // START
    req_valid = 1'b0;
    tick();                               // WAIT 1
    tick();                               // WAIT 2: flush
    flush = 1'b1;
    drive_req(4, 4, 3'b000, 6'd2, 5'd2);
    #1;
    chk("fw_ready_flush", 32'(req_ready), 0);
    tick();                               // DRAIN
    flush = 1'b0;
    #1;
    chk("fw_drain_busy",  32'(busy),      1);
    chk("fw_drain_ready", 32'(req_ready), 0);
    chk("fw_no_start",    32'(fu_start),  0);
    tick();
    fu_valid = 1'b1;
    fu_rd_v  = 32'hDEAD_BEEF;
    #1;
    chk("fw_drain_ready2", 32'(req_ready), 0);
    chk("fw_no_cdb",       32'(cdb_req),   0);
    tick();                               // back to IDLE
    fu_valid  = 1'b0;
    fu_rd_v   = '0;
    req_valid = 1'b0;
    #1;
    chk("fw_idle",     32'(busy),      0);
    chk("fw_no_cdb2",  32'(cdb_req),   0);
    chk("fw_ready",    32'(req_ready), 1);
    chk("fw_cdb_keep", cdb_rd_v,       15);

    // ---------------- flush coincident with grant ----------------
    drive_req(2, 3, 3'b000, 6'd7, 5'd8);
    tick();                               // START
    req_valid = 1'b0;
    tick();                               // WAIT 1: result
    fu_valid = 1'b1;
    fu_rd_v  = 6;
    tick();                               // DONE
    fu_valid = 1'b0;
    fu_rd_v  = '0;
    #1;
    chk("fg_cdb_req", 32'(cdb_req), 1);
    flush     = 1'b1;
    cdb_grant = 1'b1;
    drive_req(9, 9, 3'b000, 6'd9, 5'd9);
    #1;
    chk("fg_cdb_req_flush", 32'(cdb_req),   0);
    chk("fg_ready_flush",   32'(req_ready), 0);
    tick();
    flush     = 1'b0;
    cdb_grant = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("fg_idle",     32'(busy),      0);
    chk("fg_no_start", 32'(fu_start),  0);
    chk("fg_ready",    32'(req_ready), 1);
    chk("fg_rs1_kept", fu_rs1_v,       2);

    // ---------------- reset mid-op ----------------
    drive_req(11, 13, 3'b010, 6'd30, 5'd31);
    tick();                               // START
    req_valid = 1'b0;
    tick();                               // WAIT
    #1;
    chk("rm_busy_wait", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    #1;
    chk("rm_busy",     32'(busy),        0);
    chk("rm_fu_start", 32'(fu_start),    0);
    chk("rm_cdb_req",  32'(cdb_req),     0);
    chk("rm_ready",    32'(req_ready),   0);
    chk("rm_rs1",      fu_rs1_v,         0);
    chk("rm_rs2",      fu_rs2_v,         0);
    chk("rm_f3",       32'(fu_funct3),   0);
    chk("rm_cdb_rd",   cdb_rd_v,         0);
    chk("rm_cdb_pd",   32'(cdb_pd),      0);
    chk("rm_cdb_rob",  32'(cdb_rob_idx), 0);
    rst_n    = 1'b1;
    fu_valid = 1'b1;                      // stale result from the killed op
    fu_rd_v  = 32'h1234_5678;
    #1;
    chk("rm_rel_ready", 32'(req_ready), 1);
    tick();
    fu_valid = 1'b0;
    fu_rd_v  = '0;
    #1;
    chk("rm_stale_busy", 32'(busy),    0);
    chk("rm_stale_cdb",  32'(cdb_req), 0);
    chk("rm_stale_rd",   cdb_rd_v,     0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Issue-side controller for the multiplier functional unit in the out-of-order core. It accepts one ready multiply micro-op at a time from the multiply reservation station and drives the FU's `start`/operand/`funct3` inputs. It waits for the FU's one-cycle `valid` pulse, captures the result with its destination tags into a one-entry buffer, and requests the CDB until granted. On a branch flush it squashes the in-flight op and discards the late FU result.

## Interface
- PHYS_REG_BITS, 6, physical destination register tag width
- ROB_IDX_BITS, 5, ROB index width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  reservation station has a ready op
- req_ready  out  1  op accepted this cycle when high with req_valid
- req_rs1_v, req_rs2_v  in  32  source operand values
- req_funct3  in  3  mul/mulh/mulhsu/mulhu encoding, forwarded unchanged
- req_pd  in  PHYS_REG_BITS  destination physical register
- req_rob_idx  in  ROB_IDX_BITS  ROB entry
- fu_start  out  1  one-cycle start pulse to the FU
- fu_rs1_v, fu_rs2_v  out  32  latched operands to the FU
- fu_funct3  out  3  latched funct3 to the FU
- fu_valid  in  1  FU result-ready pulse, one cycle
- fu_rd_v  in  32  FU result, valid with fu_valid
- cdb_req  out  1  result buffer requests the CDB
- cdb_grant  in  1  CDB arbiter grant; transfer occurs the cycle req and grant are both high
- cdb_rd_v  out  32  buffered result
- cdb_pd  out  PHYS_REG_BITS  buffered destination tag
- cdb_rob_idx  out  ROB_IDX_BITS  buffered ROB index
- flush  in  1  global branch mispredict squash
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, WAIT, DONE, DRAIN.
- Reset (rst_n=0 at posedge):
  - state goes to IDLE.
  - All operand, funct3, tag and result registers clear to 0.
  - Every output is 0, except req_ready, which is 1 once reset is released.
- req_ready = !flush && (state==IDLE || (state==DONE && cdb_grant)).
- Accept (req_valid && req_ready):
  - Latch rs1/rs2/funct3/pd/rob_idx.
  - Next state is START.
- START:
  - fu_start=1 for exactly this cycle; fu_rs*_v and fu_funct3 come from the latched registers.
  - Next state is WAIT; with flush high, next state is DRAIN.
- WAIT:
  - On fu_valid, capture fu_rd_v into the result buffer; next state is DONE.
  - With flush high, next state is DRAIN. If fu_valid arrives in that same cycle, the result is discarded and next state is IDLE.
- DONE:
  - cdb_req = !flush.
  - On cdb_grant without flush: go to START if a new op is accepted, else IDLE.
  - With flush high, next state is IDLE and any grant that cycle is ignored (no broadcast counted).
- DRAIN:
  - Wait for fu_valid, drop the result, go to IDLE.
  - flush in DRAIN has no further effect.
  - req_ready=0 throughout.
- Operand and funct3 outputs stay stable from START until the op's fu_valid.
- fu_valid in IDLE, START or DONE is a protocol error: it is ignored and causes no state change.
- cdb_rd_v, cdb_pd and cdb_rob_idx stay stable while cdb_req is high.
- No arithmetic is performed; the 32-bit result is passed through bit-exact.

## Timing
- Accept at edge t. fu_start is high in cycle t+1.
- With FU latency L cycles from start to valid, fu_valid arrives at t+1+L. Result capture is at that edge, and cdb_req is high from t+2+L.
- Best-case accept-to-CDB latency is L+2 cycles.
- Back-to-back: a grant in cycle g with req_valid high gives fu_start in g+1, so there are no idle cycles between ops beyond the FU latency.
- At most one op is in flight and at most one result is buffered. A new FU op never starts while the buffer holds an unbroadcast result.
- flush takes effect combinationally on req_ready and cdb_req, and on state at the next edge.

## Test plan
- Single op: accept rs1=7, rs2=6, funct3=000, pd=12, rob=3; FU model returns 42 after L=4 → cdb_req rises 6 cycles after the accept edge with cdb_rd_v=42, pd=12, rob=3, and drops the cycle after grant.
- CDB backpressure: hold cdb_grant=0 for 10 cycles with result 0x40000000 (mulh, 0x80000000²) → cdb_req stays high, data stable, req_ready=0, no fu_start; grant → transfer once.
- Back-to-back: two ops queued, grant in DONE → second op accepted the same cycle and fu_start in the next; both results broadcast in order.
- Flush in WAIT: flush 2 cycles after fu_start → DRAIN, req_ready=0; FU returns 0xDEADBEEF → no cdb_req; IDLE the next cycle.
- Flush coincident with cdb_grant in DONE → cdb_req=0 that cycle; IDLE the next cycle; a req_valid in that cycle is not accepted.
- Reset mid-op: rst_n=0 during WAIT → all outputs 0 and IDLE the next cycle; a stale fu_valid after release is ignored.
